matrixmult_sdiv_32s_16s_seq: RTL and testbench



---
 rtl/matrixmult_div_pkg.sv | 8 +
 rtl/matrixmult_sdiv_step.sv | 17 +
 rtl/matrixmult_sdiv_32s_16s_seq.sv | 87 ++++++++
 tb/tb_matrixmult_sdiv_32s_16s_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/matrixmult_div_pkg.sv
// matrixmult_div_pkg: shared types and constants for the MatrixMult sequential divider
package matrixmult_div_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  localparam int DIV_DIVIDEND_W = 32;
  localparam int DIV_DIVISOR_W = 16;
  localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN = 32'h8000_0000;
endpackage

// File: rtl/matrixmult_sdiv_step.sv
// matrixmult_sdiv_step: one combinational restoring-division step on unsigned magnitudes
module matrixmult_sdiv_step #(
  parameter int W = 16
) (
  input  logic [W:0]   part,
  input  logic         bit_in,
  input  logic [W-1:0] dabs,
  output logic [W:0]   part_nx,
  output logic         q_bit
);
  logic [W:0] sh;
  always_comb begin
    sh = (part << 1) | {{W{1'b0}}, bit_in};
    q_bit = sh >= {1'b0, dabs};
    part_nx = q_bit ? sh - {1'b0, dabs} : sh;
  end
endmodule

// File: rtl/matrixmult_sdiv_32s_16s_seq.sv
// matrixmult_sdiv_32s_16s_seq: signed restoring divider, one quotient bit per ce-cycle
module matrixmult_sdiv_32s_16s_seq
  import matrixmult_div_pkg::*;
#(
  parameter int din0_WIDTH = DIV_DIVIDEND_W,
  parameter int din1_WIDTH = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [din0_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero,
  output logic                  ovf
);
  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [din0_WIDTH-1:0] QMAX = {1'b0, {(din0_WIDTH-1){1'b1}}};
  localparam logic [din0_WIDTH-1:0] QMIN = ~QMAX;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [din0_WIDTH-1:0] a;
  logic [din1_WIDTH-1:0] dabs;
  logic [din1_WIDTH:0] part, part_nx;
  logic q_bit, sign_q, sign_r, zero, ovf_f;
  assign in_ready = ce & (state == IDLE);
  assign out_valid = state == DONE;
  matrixmult_sdiv_step #(.W(din1_WIDTH)) u_step (
    .part   (part),
    .bit_in (a[din0_WIDTH-1]),
    .dabs   (dabs),
    .part_nx(part_nx),
    .q_bit  (q_bit)
  );
  always_comb begin
    state_nx = state;
    if (ce)
      state_nx = state == IDLE ? (in_valid ? ITER : IDLE) :
                 state == ITER ? (cnt == '0 ? FIX : ITER) :
                 state == FIX  ? DONE :
                 (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // a doubles as dividend shifter (MSB out) and quotient accumulator (LSB in)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      a <= '0;
      dabs <= '0;
      part <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      zero <= 1'b0;
      ovf_f <= 1'b0;
      quot <= '0;
      rem <= '0;
      div_zero <= 1'b0;
      ovf <= 1'b0;
    end else if (in_valid && in_ready) begin
      cnt <= CW'(din0_WIDTH - 1);
      a <= din0[din0_WIDTH-1] ? -din0 : din0;
      dabs <= din1[din1_WIDTH-1] ? -din1 : din1;
      part <= '0;
      sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
      sign_r <= din0[din0_WIDTH-1];
      zero <= din1 == '0;
      ovf_f <= (din0 == QMIN) && (din1 == '1);
    end else if (ce && state == ITER) begin
      a <= {a[din0_WIDTH-2:0], q_bit};
      part <= part_nx;
      cnt <= cnt == '0 ? cnt : cnt - 1'b1;
    end else if (ce && state == FIX) begin
      quot <= zero ? (sign_r ? QMIN : QMAX) : ovf_f ? QMAX : sign_q ? -a : a;
      rem <= (zero | ovf_f) ? '0 : sign_r ? -part[din1_WIDTH-1:0] : part[din1_WIDTH-1:0];
      div_zero <= zero;
      ovf <= ovf_f & ~zero;
    end
  end
endmodule

// File: tb/tb_matrixmult_sdiv_32s_16s_seq.sv
// tb_matrixmult_sdiv_32s_16s_seq: scoreboard bench for the sequential signed divider
module tb_matrixmult_sdiv_32s_16s_seq;
  import matrixmult_div_pkg::*;
  typedef struct packed {logic [31:0] q; logic [15:0] r; logic dz; logic ov;} exp_t;
  logic clk = 0, reset = 0, ce = 1, in_valid = 0, out_ready = 1;
  logic [31:0] din0 = 0;
  logic [15:0] din1 = 0;
  logic in_ready, out_valid, div_zero, ovf;
  logic [31:0] quot;
  logic [15:0] rem;
  int total = 0, bad = 0;
  exp_t scb[$];

  always #5 clk = ~clk;

  matrixmult_sdiv_32s_16s_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .div_zero(div_zero), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [15:0] r, input logic dz, input logic ov);
    mk = {q, r, dz, ov};
  endfunction

  function automatic exp_t ref_div(input logic [31:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sd, q, r;
    sa = a;
    sd = {{16{b[15]}}, b};
    if (b == 16'h0) return mk(a[31] ? Q_MIN : Q_MAX, 16'h0, 1'b1, 1'b0);
    if (a == Q_MIN && b == 16'hFFFF) return mk(Q_MAX, 16'h0, 1'b0, 1'b1);
    q = sa / sd;
    r = sa % sd;
    return mk(q, r[15:0], 1'b0, 1'b0);
  endfunction

  // monitor: compare whenever a result handshake is about to complete
  always @(negedge clk) begin
    if (out_valid && out_ready && ce) begin
      total++;
      if (scb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output quot=%h rem=%h", quot, rem);
      end else begin
        exp_t e;
        e = scb.pop_front();
        if ({quot, rem, div_zero, ovf} !== e) begin
          bad++;
          $display("FAIL result got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
                   quot, rem, div_zero, ovf, e.q, e.r, e.dz, e.ov);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL idle_timeout in_ready=%b want 1", in_ready);
    end
  endtask

  // accept latency counts the accept edge as edge 1
  task automatic issue(input logic [31:0] a, input logic [15:0] b, input exp_t e, input int exp_lat);
    int n = 0;
    din0 = a; din1 = b; in_valid = 1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    scb.push_back(e);
    #1;
    in_valid = 0; din0 = $urandom; din1 = 16'($urandom);
    n = 1;
    while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
    if (exp_lat > 0) chk("latency", n, exp_lat);
  endtask

  initial begin
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 0;
    issue(32'd100, 16'd7, mk(32'd14, 16'd2, 0, 0), 34);
    issue(32'hFFFF_FFF9, 16'd2, mk(32'hFFFF_FFFD, 16'hFFFF, 0, 0), 34);
    issue(32'd7, 16'hFFFE, mk(32'hFFFF_FFFD, 16'd1, 0, 0), 34);
    issue(32'hFFFF_FFFB, 16'd0, mk(Q_MIN, 16'd0, 1, 0), 34);
    issue(32'd5, 16'd0, mk(Q_MAX, 16'd0, 1, 0), 34);
    issue(32'd0, 16'd0, mk(Q_MAX, 16'd0, 1, 0), 34);
    issue(Q_MIN, 16'hFFFF, mk(Q_MAX, 16'd0, 0, 1), 34);
    issue(Q_MIN, 16'h8000, mk(32'd65536, 16'd0, 0, 0), 34);
    issue(Q_MAX, 16'd1, mk(Q_MAX, 16'd0, 0, 0), 34);
    issue(Q_MIN, 16'd1, mk(Q_MIN, 16'd0, 0, 0), 34);
    issue(32'hFFFF_FF9C, 16'hFFF9, mk(32'd14, 16'hFFFE, 0, 0), 34);
    issue(32'd0, 16'd5, mk(32'd0, 16'd0, 0, 0), 34);
    // backpressure: result must hold while out_ready is low
    wait_idle();
    out_ready = 0;
    issue(32'd100, 16'd7, mk(32'd14, 16'd2, 0, 0), 34);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_quot", quot, 32'd14);
      chk("bp_rem", rem, 16'd2);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    // clock-enable stall in the middle of the iterations
    wait_idle();
    fork
      issue(32'd1000, 16'hFFFD, mk(32'hFFFF_FEB3, 16'd1, 0, 0), 39);
      begin
        repeat (10) @(posedge clk);
        #1 ce = 0;
        repeat (5) @(posedge clk);
        #1 ce = 1;
      end
    join
    // asynchronous reset mid-operation
    wait_idle();
    din0 = 32'd1000; din1 = 16'd3; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_quot", quot, 0);
    chk("abort_rem", rem, 0);
    chk("abort_div_zero", div_zero, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 0;
    begin
      int seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      chk("abort_no_output", seen, 0);
    end
    issue(32'd42, 16'd6, mk(32'd7, 16'd0, 0, 0), 34);
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      a = $urandom;
      b = 16'($urandom);
      if (i % 10 == 3) b = 16'h0;
      if (i % 10 == 7) b = 16'($urandom_range(1, 20));
      if (i % 25 == 5) begin a = Q_MIN; b = 16'hFFFF; end
      issue(a, b, ref_div(a, b), 34);
    end
    wait_idle();
    chk("scoreboard_empty", scb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
